// File: rtl/sfq_pulse_tx.sv
// sfq_pulse_tx: clocked-to-SFQ boundary transmitter.
// Buffers DATA_W-bit words in a small FIFO and serialises them into fixed-width
// bit slots on a toggle-encoded line q. Each '1' bit produces exactly one
// transition of q at the start of its slot. A '0' bit produces no transition.
module sfq_pulse_tx #(
  parameter int DATA_W         = 8,
  parameter int BIT_CYCLES     = 4,
  parameter int STARTUP_CYCLES = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int LSB_FIRST      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              q,
  output logic              busy,
  output logic [15:0]       pulse_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int SW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int UW = $clog2(STARTUP_CYCLES + 1);

  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(BIT_CYCLES - 1);
  localparam logic [UW-1:0] LAST_SU   = UW'(STARTUP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e            state_q, state_d;
  logic [UW-1:0]     su_cnt_q, su_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [SW-1:0]     slot_q, slot_d;
  logic              q_q, q_d;
  logic [15:0]       pc_q, pc_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic              push;
  logic              pop;
  logic              cur_bit;
  logic              last_slot;
  logic [BW-1:0]     cur_idx;

  assign in_ready    = (state_q != ST_STARTUP) && (count_q < FIFO_FULL);
  assign push        = in_valid && in_ready;
  assign busy        = (state_q == ST_SHIFT) || (count_q != '0);
  assign q           = q_q;
  assign pulse_count = pc_q;

  // Next-state logic: startup timer, word load, slot/bit sequencing, pulse emission.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d   = state_q;
    su_cnt_d  = su_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    slot_d    = slot_q;
    q_d       = q_q;
    pc_d      = pc_q;
    pop       = 1'b0;

    cur_idx   = (LSB_FIRST != 0) ? bit_idx_q : (LAST_BIT - bit_idx_q);
    cur_bit   = shreg_q[cur_idx];
    last_slot = (slot_q == LAST_SLOT) && (bit_idx_q == LAST_BIT);

    case (state_q)
      ST_STARTUP: begin
        if (su_cnt_q == LAST_SU) begin
          state_d = ST_IDLE;
        end else begin
          su_cnt_d = su_cnt_q + UW'(1);
        end
      end
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      ST_SHIFT: begin
        if ((slot_q == '0) && cur_bit) begin
          q_d = ~q_q;
          if (pc_q != 16'hFFFF) begin
            pc_d = pc_q + 16'd1;
          end
        end
        if (last_slot) begin
          // Chain straight into the next word so there is no gap between words.
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (slot_q == LAST_SLOT) begin
          slot_d    = '0;
          bit_idx_d = bit_idx_q + BW'(1);
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (pop) begin
      shreg_d   = mem_q[rd_ptr_q];
      bit_idx_d = '0;
      slot_d    = '0;
      state_d   = ST_SHIFT;
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample its pre-edge inputs,
    // so ordering of statements here does not matter.
    if (rst) begin
      state_q   <= ST_STARTUP;
      su_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      slot_q    <= '0;
      q_q       <= 1'b0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      su_cnt_q  <= su_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      slot_q    <= slot_d;
      q_q       <= q_d;
      pc_q      <= pc_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptiness is tracked by count_q and
    // the pointers, so stale entries are never read.
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_sfq_pulse_tx.sv
// Bench for sfq_pulse_tx: stimulus pushes expected transition cycles and
// pulse counts into a scoreboard; a monitor pops them whenever q changes.
// A second instance with one-cycle slots exercises pulse_count saturation.
module tb_sfq_pulse_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        q;
  logic        busy;
  logic [15:0] pulse_count;

  sfq_pulse_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q          (q),
    .busy       (busy),
    .pulse_count(pulse_count)
  );

  logic        rst_s;
  logic [7:0]  data_s;
  logic        valid_s;
  logic        ready_s;
  logic        q_s;
  logic        busy_s;
  logic [15:0] pc_s;

  sfq_pulse_tx #(.BIT_CYCLES(1), .STARTUP_CYCLES(2)) dut_sat (
    .clk        (clk),
    .rst        (rst_s),
    .in_data    (data_s),
    .in_valid   (valid_s),
    .in_ready   (ready_s),
    .q          (q_s),
    .busy       (busy_s),
    .pulse_count(pc_s)
  );

  typedef struct {
    int t;
    int pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp     = 0;
  int   n_err     = 0;
  int   cyc       = 0;
  int   exp_pc    = 0;
  int   last_load = -1000;
  bit   mon_en    = 1'b0;
  bit   sat_done  = 1'b0;
  logic q_prev    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timeline: a word accepted at edge e is loaded at max(e+1, previous
  // load + 32); bit k's transition (if set) lands at load + 1 + 4*k.
  task automatic model_word(input logic [7:0] w, input int e);
    int l;
    l = (e + 1 > last_load + 32) ? e + 1 : last_load + 32;
    last_load = l;
    for (int k = 0; k < 8; k++) begin
      if (w[k]) begin
        if (exp_pc < 65535) exp_pc++;
        sb.push_back('{l + 1 + 4 * k, exp_pc});
      end
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [7:0] w, input bit keep, output int e);
    int n;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, word 0x%0h", n, w);
      in_valid = 1'b0;
      e = cyc;
      return;
    end
    e = cyc + 1;
    model_word(w, e);
    @(posedge clk);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: counts edges and matches every transition of q against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].t < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL missing_pulse: no transition seen at cycle %0d, expected one there", sb[0].t);
        void'(sb.pop_front());
      end
      if (q !== q_prev) begin
        if (mon_en) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_pulse: transition at cycle %0d, expected none", cyc);
          end else begin
            mon_e = sb.pop_front();
            check("pulse_cycle", cyc, mon_e.t);
            check("pulse_count_at_pulse", {16'd0, pulse_count}, mon_e.pc);
          end
        end
        q_prev = q;
      end
    end
  end

  // Saturation: one-cycle slots, continuous 0xFF words.
  initial begin
    int   n;
    logic qp;
    logic qexp;
    rst_s   = 1'b1;
    valid_s = 1'b0;
    data_s  = 8'hFF;
    repeat (2) @(negedge clk);
    rst_s   = 1'b0;
    valid_s = 1'b1;
    n = 0;
    while (pc_s !== 16'hFFFF && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("sat_reached", {16'd0, pc_s}, 32'h0000FFFF);
    qp = q_s;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      qexp = ~qp;
      check("sat_hold", {16'd0, pc_s}, 32'h0000FFFF);
      check("sat_toggle", {31'd0, q_s}, {31'd0, qexp});
      qp = q_s;
    end
    sat_done = 1'b1;
  end

  // Directed stimulus.
  initial begin
    int e;
    int e0;
    int l;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_q", {31'd0, q}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulse_count", {16'd0, pulse_count}, 32'd0);
    q_prev = q;
    mon_en = 1'b1;
    rst    = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("startup_in_ready", {31'd0, in_ready}, {31'd0, (k >= 8)});
      check("startup_q", {31'd0, q}, 32'd0);
    end

    // 0xA5: transitions at E+2, E+10, E+22, E+30.
    send(8'hA5, 1'b0, e);
    wait_until(e + 32);
    check("a5_busy_last_slot", {31'd0, busy}, 32'd1);
    wait_until(e + 33);
    check("a5_busy_done", {31'd0, busy}, 32'd0);
    check("a5_pulse_count", {16'd0, pulse_count}, 32'd4);

    // All-zero word: full-length busy window, no transitions.
    send(8'h00, 1'b0, e);
    check("zero_busy_start", {31'd0, busy}, 32'd1);
    wait_until(e + 32);
    check("zero_busy_end", {31'd0, busy}, 32'd1);
    wait_until(e + 33);
    check("zero_busy_done", {31'd0, busy}, 32'd0);
    check("zero_pulse_count", {16'd0, pulse_count}, 32'd4);

    // MSB-only word: single transition in the last slot.
    send(8'h80, 1'b0, e);
    wait_until(e + 33);
    check("w80_pulse_count", {16'd0, pulse_count}, 32'd5);
    check("w80_busy_done", {31'd0, busy}, 32'd0);

    // Backpressure: six 0x01 words queued behind a transmitting word.
    send(8'h00, 1'b1, e0);
    for (int i = 0; i < 6; i++) begin
      send(8'h01, (i < 5), e);
      if (i == 3) check("full_in_ready", {31'd0, in_ready}, 32'd0);
    end
    wait_until(last_load + 31);
    check("bp_busy_tail", {31'd0, busy}, 32'd1);
    wait_until(last_load + 32);
    check("bp_busy_done", {31'd0, busy}, 32'd0);
    check("bp_pulse_count", {16'd0, pulse_count}, 32'd11);

    // Reset during bit 3 of 0xFF.
    send(8'hFF, 1'b0, e);
    l = e + 1;
    wait_until(l + 14);
    check("mid_pending", sb.size(), 32'd4);
    check("mid_q_before_reset", {31'd0, q}, 32'd1);
    sb.delete();
    mon_en = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check("rst_mid_q", {31'd0, q}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_pulse_count", {16'd0, pulse_count}, 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    exp_pc    = 0;
    last_load = -1000;
    q_prev    = q;
    mon_en    = 1'b1;
    rst       = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("restart_in_ready", {31'd0, in_ready}, {31'd0, (k >= 8)});
    end
    send(8'h03, 1'b0, e);
    wait_until(e + 33);
    check("after_reset_pulse_count", {16'd0, pulse_count}, 32'd2);
    check("after_reset_busy", {31'd0, busy}, 32'd0);

    check("scoreboard_drained", sb.size(), 32'd0);
    while (!sat_done) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sfq_pulse_tx.md
Name: sfq_pulse_tx

Overview:
- Clocked-domain transmitter that drives a toggle-encoded SFQ pulse line. On that line every transition, rising or falling, is one pulse.
- Accepts DATA_W-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word into fixed-width bit slots. A '1' bit emits exactly one transition on q; a '0' bit emits none.
- Sits at the clocked-to-SFQ boundary and feeds JTL chains and other toggle-encoded cells. It holds the line quiet for a startup interval after reset.

Parameters:
- DATA_W, 8, width of each transmitted word.
- BIT_CYCLES, 4, clock cycles per bit slot (>=1). This sets the minimum pulse spacing downstream cells see.
- STARTUP_CYCLES, 8, cycles after reset deassertion during which input is refused and q is held.
- FIFO_DEPTH, 4, input buffer entries (power of 2, >=2).
- LSB_FIRST, 1, 1 = bit 0 transmitted first, 0 = bit DATA_W-1 first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- q  output  1  toggle-encoded SFQ pulse line, registered.
- busy  output  1  word in FIFO or being shifted.
- pulse_count  output  16  saturating count of transitions emitted on q since reset.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: q=0, in_ready=0, busy=0, pulse_count=0, FIFO empty, state=STARTUP, all counters 0.
- States: STARTUP, IDLE, SHIFT.
- STARTUP: counts STARTUP_CYCLES rising edges with rst low, then goes to IDLE. During STARTUP, in_ready=0 and q is held.
- in_ready = (state!=STARTUP) && (fifo_count<FIFO_DEPTH). This is combinational from registered state.
- Accept: occurs on any edge with in_valid && in_ready. When the FIFO is full, no push happens even if a pop occurs on the same edge.
- Simultaneous push and pop with a non-full FIFO: both occur; fifo_count is unchanged.
- IDLE with FIFO non-empty: pop the head into the shift register on the next edge. Set state=SHIFT, bit_idx=0, slot_cnt=0.
- SHIFT, each edge: if slot_cnt==0 and the current bit is 1, then q<=~q and pulse_count increments (saturating at 16'hFFFF). slot_cnt increments modulo BIT_CYCLES; on wrap, bit_idx increments.
- End of last slot of last bit:
  - FIFO non-empty: load the next word on that same edge (bit_idx=0, slot_cnt=0). No idle gap between words.
  - FIFO empty: go to IDLE.
- Latency: word accepted at edge E into an idle, empty block → loaded at E+1 → bit k's transition (if 1) at edge E+2+BIT_CYCLES*k. The word occupies DATA_W*BIT_CYCLES edges, E+2 through E+1+DATA_W*BIT_CYCLES.
- '0' bits consume their full slot with no transition. An all-zero word is still transmitted in full and takes full time.
- Transition spacing: transitions on q are never closer than BIT_CYCLES cycles, including across word boundaries.
- busy = (state==SHIFT) || (fifo_count!=0).
- Polarity: q carries no meaning, only its transitions do. q holds its last value while idle; it does not return to 0 between words.
- Reset mid-operation: the shifted word and FIFO contents are discarded. q is forced to 0 and STARTUP restarts. If q was 1, this forced edge is not counted. Downstream cells must be reset in the same window, and the system reset sequence guarantees this.

Test Plan:
- Startup: rst high 2 cycles, then low → in_ready=0 for 8 edges, 1 from the 9th edge. q=0 and pulse_count=0 throughout.
- Single word 0xA5, LSB_FIRST=1, accepted at edge E → q toggles at E+2, E+10, E+22, E+30 (bits 0,2,5,7). pulse_count=4. busy low after E+33.
- Word 0x00 → no transitions on q for 32 cycles. busy high for exactly that window. pulse_count unchanged.
- Backpressure: push 6 words of 0x01 back-to-back during transmission → in_ready drops when 4 are buffered. All 6 are sent in order, transitions exactly 32 cycles apart with no gap. pulse_count=6.
- Reset mid-word (during bit 3 of 0xFF) → next edge: q=0, busy=0, pulse_count=0, in_ready=0. No further transitions until a new word is sent after 8 startup cycles.
- Saturation: 8192 words of 0xFF → pulse_count reaches 16'hFFFF and holds there. q keeps toggling once per slot.
